// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_if
// Description : Operand/result bundle for the word-serial ALU. The master
//               side issues START/OP/operands; the slave side returns the
//               registered result and the BUSY/DONE status.
//               ZERO is present only when SEQ_ALU_ZERO_FLAG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
);
    localparam int N = WIDTH * WORDS;

    logic           START;
    logic [3:0]     OP;
    logic           SC_IN;
    logic [N-1:0]   INPUTA;
    logic [N-1:0]   INPUTB;
    logic [N-1:0]   OUT;
    logic           SC_OUT;
    logic           BUSY;
    logic           DONE;
`ifdef SEQ_ALU_ZERO_FLAG_EN
    logic           ZERO;

    modport master (
        output START, OP, SC_IN, INPUTA, INPUTB,
        input  OUT, SC_OUT, BUSY, DONE, ZERO
    );

    modport slave (
        input  START, OP, SC_IN, INPUTA, INPUTB,
        output OUT, SC_OUT, BUSY, DONE, ZERO
    );
`else
    modport master (
        output START, OP, SC_IN, INPUTA, INPUTB,
        input  OUT, SC_OUT, BUSY, DONE
    );

    modport slave (
        input  START, OP, SC_IN, INPUTA, INPUTB,
        output OUT, SC_OUT, BUSY, DONE
    );
`endif
endinterface
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Word-serial ALU. Operands of WIDTH*WORDS bits are processed
//               one WIDTH-bit word per cycle, LSW first, with a chain bit
//               (carry / shift bit) passed between words.
//               Ops: 0=ADD 1=LSA 2=XOR 3=SUB, others yield zero.
//               Optional: SEQ_ALU_ZERO_FLAG_EN adds the registered ZERO flag.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  wire logic   CLK,
    input  wire logic   RESET_N,
    seq_alu_if.slave    bus
);
    localparam int N  = WIDTH * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [3:0]    c_OP_ADD  = 4'd0;
    localparam logic [3:0]    c_OP_LSA  = 4'd1;
    localparam logic [3:0]    c_OP_XOR  = 4'd2;
    localparam logic [3:0]    c_OP_SUB  = 4'd3;
    localparam logic [KW-1:0] c_K_LAST  = KW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [KW-1:0]      r_k;
    logic               r_c;
    logic [3:0]         r_op;
    // Latched operands shift right one word per cycle so word k is always
    // at the bottom; the result shifts in from the top in the same way.
    logic [N-1:0]       r_a;
    logic [N-1:0]       r_b;
    logic [N-1:0]       r_res;
    logic [N-1:0]       r_out;
    logic               r_sc_out;

    logic [WIDTH-1:0]   w_a_k;
    logic [WIDTH-1:0]   w_b_k;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_r_k;
    logic               w_c_nx;
    logic               w_c_init;
    logic [N+WIDTH-1:0] w_res_cat;
    logic [N-1:0]       w_res_nx;
    logic               w_last;
    logic               w_busy;
    logic               w_done;

    assign w_a_k     = r_a[WIDTH-1:0];
    assign w_b_k     = r_b[WIDTH-1:0];
    assign w_res_cat = {w_r_k, r_res};
    assign w_res_nx  = w_res_cat[N+WIDTH-1:WIDTH];
    assign w_last    = (r_k == c_K_LAST);

    // Per-word operation: result word and outgoing chain bit.
    always_comb begin
        w_sum  = '0;
        w_r_k  = '0;
        w_c_nx = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_sum  = {1'b0, w_a_k} + {1'b0, w_b_k} + {{WIDTH{1'b0}}, r_c};
                w_r_k  = w_sum[WIDTH-1:0];
                w_c_nx = w_sum[WIDTH];
            end
            c_OP_SUB: begin
                w_sum  = {1'b0, w_a_k} + {1'b0, ~w_b_k} + {{WIDTH{1'b0}}, r_c};
                w_r_k  = w_sum[WIDTH-1:0];
                w_c_nx = w_sum[WIDTH];
            end
            c_OP_LSA: begin
                w_r_k  = {w_a_k[WIDTH-2:0], r_c};
                w_c_nx = w_a_k[WIDTH-1];
            end
            c_OP_XOR: begin
                w_r_k  = w_a_k ^ w_b_k;
                w_c_nx = 1'b0;
            end
            default: begin
                w_r_k  = '0;
                w_c_nx = 1'b0;
            end
        endcase
    end

    // Chain-bit seed chosen from the opcode being launched (SUB seeds the +1
    // of two's complement; XOR and illegal ops keep the chain at zero).
    always_comb begin
        w_c_init = 1'b0;
        case (bus.OP)
            c_OP_ADD, c_OP_LSA: w_c_init = bus.SC_IN;
            c_OP_SUB:           w_c_init = 1'b1;
            default:            w_c_init = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next state and status outputs; START is only honoured in IDLE.
    always_comb begin
        w_state_nx = r_state;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.START) begin
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nx = S_FIN;
                end
            end
            S_FIN: begin
                w_busy     = 1'b1;
                w_done     = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Datapath: latch on launch, step one word per RUN cycle, publish the
    // result only on the edge that enters FIN.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_k      <= '0;
            r_c      <= 1'b0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_out    <= '0;
            r_sc_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.START) begin
                        r_a   <= bus.INPUTA;
                        r_b   <= bus.INPUTB;
                        r_op  <= bus.OP;
                        r_c   <= w_c_init;
                        r_k   <= '0;
                        r_res <= '0;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> WIDTH;
                    r_b   <= r_b >> WIDTH;
                    r_c   <= w_c_nx;
                    r_res <= w_res_nx;
                    r_k   <= r_k + 1'b1;
                    if (w_last) begin
                        r_out    <= w_res_nx;
                        r_sc_out <= w_c_nx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SEQ_ALU_ZERO_FLAG_EN
    logic r_zero;

    // Zero flag captured together with OUT.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_zero <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_zero <= (w_res_nx == '0);
        end
    end

    assign bus.ZERO = r_zero;
`endif

    assign bus.OUT    = r_out;
    assign bus.SC_OUT = r_sc_out;
    assign bus.BUSY   = w_busy;
    assign bus.DONE   = w_done;

endmodule
`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8: bits per word processed per cycle, legal range 2 to 32.
REQ-002 Parameter WORDS, default 4: words per operand, legal range 1 to 16; N = WIDTH*WORDS.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 START  input  1  request a new operation; sampled only in IDLE.
REQ-006 OP  input  4  opcode: 0=ADD, 1=LSA (shift left, SC_IN in), 2=XOR, 3=SUB; 4-15 illegal.
REQ-007 SC_IN  input  1  shift-in / carry-in for ADD and LSA.
REQ-008 INPUTA, INPUTB  input  N each  operands.
REQ-009 OUT  output  N  registered result.
REQ-010 SC_OUT  output  1  registered shift-out / carry-out.
REQ-011 BUSY  output  1  high while an operation is in progress.
REQ-012 DONE  output  1  single-cycle pulse: OUT and SC_OUT valid.
REQ-013 ZERO  output  1  result-equals-zero flag; present only per REQ-030.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and FIN.
REQ-015 In IDLE with START=1, the block SHALL latch INPUTA, INPUTB, OP and SC_IN, clear word index k to 0, and go to RUN.
REQ-016 Chain-bit initial value: SC_IN for ADD and LSA; 1 for SUB, with SC_IN ignored; 0 for XOR.
REQ-017 RUN SHALL process one word per cycle, LSW first (k = 0 .. WORDS-1), then go to FIN after word WORDS-1.
REQ-018 ADD: {c, r_k} = a_k + b_k + c, in WIDTH+1-bit arithmetic.
REQ-019 SUB: {c, r_k} = a_k + ~b_k + c; final c=1 means no borrow.
REQ-020 LSA: r_k = {a_k[WIDTH-2:0], c}; next c = a_k[WIDTH-1].
REQ-021 XOR: r_k = a_k ^ b_k; c remains 0.
REQ-022 Illegal OP: r_k = 0 and c = 0 for every word; the block SHALL still take the full latency and pulse DONE.
REQ-023 FIN SHALL last exactly one cycle, then return to IDLE.
REQ-024 OUT and SC_OUT SHALL update only on the edge entering FIN and SHALL hold between operations; SC_OUT = final c.
REQ-025 DONE=1 exactly in FIN; BUSY=1 in RUN and FIN.
REQ-026 Latency: DONE SHALL assert WORDS+1 cycles after the edge that samples START.
REQ-027 START while BUSY=1 SHALL be ignored, and operand or OP changes during RUN SHALL not affect the result.
REQ-028 START asserted in FIN SHALL be ignored; back-to-back operations therefore start no sooner than IDLE.

Reset
REQ-029 RESET_N low SHALL immediately force IDLE and clear OUT, SC_OUT, BUSY, DONE, ZERO, k, the chain bit and the latched operands; reset mid-RUN aborts the operation with no DONE.

Configuration
REQ-030 Macro SEQ_ALU_ZERO_FLAG_EN defined: port ZERO exists, registered alongside OUT; it is 1 if OUT of the completed operation is all-zero, else 0, and holds between operations.
REQ-031 Macro SEQ_ALU_ZERO_FLAG_EN undefined: port ZERO and its logic are absent; all other behaviour is identical.

Verification (WIDTH=8, WORDS=4)
REQ-032 ADD, A=0x000000FF, B=0x00000001, SC_IN=0 -> OUT=0x00000100, SC_OUT=0, DONE exactly 5 cycles after START sampled.
REQ-033 ADD, A=0xFFFFFFFF, B=0x00000001, SC_IN=0 -> OUT=0x00000000, SC_OUT=1, ZERO=1 (macro on).
REQ-034 LSA, A=0x80808080, SC_IN=1 -> OUT=0x01010101, SC_OUT=1.
REQ-035 SUB, A=0x00000000, B=0x00000001, SC_IN=1 -> OUT=0xFFFFFFFF, SC_OUT=0; SUB, A=5, B=3 -> OUT=0x00000002, SC_OUT=1.
REQ-036 XOR, A=0x12345678, B=0x12345678; second START and operand change during RUN -> one DONE only, OUT=0, ZERO=1.
REQ-037 RESET_N low for one cycle during the 2nd RUN cycle -> BUSY=0 and OUT=0 immediately, no DONE pulse; next START completes normally.
